// File: rtl/sub_shift_stage.sv
// SubBytes (LANES S-boxes per cycle) followed by Nb=8 ShiftRows.
// Result is held on a valid/ready port feeding the column mixer.
module sub_shift_stage #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_state,
  output logic         busy
);

  localparam int NSTEP = 32 / LANES;
  localparam int CW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    SHIFT,
    HOLD
  } state_e;

  state_e        st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [255:0]  work_q, work_d;
  logic [255:0]  out_q, out_d;
  logic          ov_q, ov_d;
  logic [255:0]  sub_w;
  logic [255:0]  shift_w;

  function automatic logic [7:0] sbox(
    input logic [7:0] b
  );
    return SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  function automatic int row_off(input int r);
    case (r)
      1:       return 1;
      2:       return 3;
      3:       return 4;
      default: return 0;
    endcase
  endfunction

  always_comb begin
    int k;
    k = 0;
    sub_w = work_q;
    for (int l = 0; l < LANES; l++) begin
      k = int'(cnt_q) * LANES + l;
      sub_w[255-8*k -: 8] = sbox(work_q[255-8*k -: 8]);
    end
  end

  // out byte (c,r) takes working byte ((c+C_r) mod 8, r)
  always_comb begin
    shift_w = '0;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_w[255-8*(c*4+r) -: 8] =
          work_q[255-8*(((c+row_off(r))%8)*4+r) -: 8];
      end
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    work_d = work_q;
    out_d  = out_q;
    ov_d   = ov_q;
    unique case (st_q)
      IDLE: begin
        if (in_valid) begin
          work_d = in_state;
          cnt_d  = '0;
          st_d   = SUB;
        end
      end
      SUB: begin
        work_d = sub_w;
        if (cnt_q == LAST) begin
          cnt_d = '0;
          st_d  = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        out_d = shift_w;
        ov_d  = 1'b1;
        st_d  = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          ov_d = 1'b0;
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      work_q <= '0;
      out_q  <= '0;
      ov_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      work_q <= work_d;
      out_q  <= out_d;
      ov_q   <= ov_d;
    end
  end

  assign in_ready  = (st_q == IDLE);
  assign busy      = (st_q == SUB);
  assign out_valid = ov_q;
  assign out_state = out_q;

endmodule
